mem_ram_arbiter: RTL
====================

// Module: mem_ram_arbiter
// PURPOSE
//  Two-port arbiter that shares one single-port 32x8 synchronous RAM between two requesters,
//  e.g. instruction fetch (port 0) and data load/store (port 1).
//  It issues RAM commands through registers, returns read data with a RVALID pulse, and
//  supports round-robin ownership with bounded bursts.
//  RAM contract: WE=1 writes D at the CLOCK edge; WE=0 loads Q from Address at the CLOCK edge.
// PARAMETERS
//  ADDR_W     5  RAM address width
//  DATA_W     8  RAM data width
//  MAX_BURST  4  max consecutive grants to one port while the other port waits (>=1)
// PORTS
//  CLOCK        in   1       system clock; all state updates on posedge
//  RESET        in   1       asynchronous, active-high reset
//  REQn         in   1       n=0,1: command request; hold with WEn/ADDRn/Dn until GNTn at an edge
//  WEn          in   1       1=write, 0=read
//  ADDRn        in   ADDR_W  command address
//  Dn           in   DATA_W  write data
//  GNTn         out  1       combinational; REQn&GNTn at posedge = command accepted
//  RVALIDn      out  1       registered; one-cycle pulse, read data for port n on Qn
//  Qn           out  DATA_W  = RAM_Q (pass-through); meaningful only while RVALIDn=1
//  RAM_ADDRESS  out  ADDR_W  registered RAM address
//  RAM_D        out  DATA_W  registered RAM write data
//  RAM_WE       out  1       registered RAM write enable
//  RAM_Q        in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset (async): state=IDLE, last=1 (port 0 wins first), burst_cnt=0, RAM_WE=0,
//   RAM_ADDRESS=0, RAM_D=0, read pipeline cleared, RVALID0=RVALID1=0.
//   An in-flight read is dropped and never signals RVALID.
//  FSM states: IDLE (no owner), OWN0, OWN1. GNT goes only to the owner or to the arbitration winner.
//   IDLE:  one REQ     -> that port granted this cycle, next state OWNn, burst_cnt=1.
//          both REQ    -> port !=last granted; last <= winner.
//          no REQ      -> stay IDLE.
//   OWNn, REQn=1:
//     burst_cnt<MAX_BURST, or other REQ=0 -> GNTn=1; burst_cnt++ (saturates at MAX_BURST when
//       other REQ=0, restarts at 1 once other requests).
//     burst_cnt==MAX_BURST and other REQ=1 -> GNT to other port, state OWNother, burst_cnt=1, last<=other.
//   OWNn, REQn=0: other REQ=1 -> switch as above; else -> IDLE, burst_cnt=0.
//  At most one GNT high per cycle; a grant is issued every cycle a REQ is eligible
//   (back-to-back throughput 1/cycle).
//  Accept at edge E0: RAM_ADDRESS/RAM_D/RAM_WE load the command. No accept: RAM_WE<=0, addr/data hold.
//   The idle RAM_WE=0 causes a harmless re-read.
//  Read latency: the RAM samples at E1; RVALIDn=1 for the cycle E1..E2 and Qn=RAM_Q.
//   RVALID follows accept by 2 edges, in grant order, with no reordering.
//  Write: done at E1; no RVALID. Write then read of the same address on the next cycle
//   returns the new data, because the RAM serializes them.
//  RVALID tag: a 2-stage shift of {valid,port}. Stage 1 loads on a read accept; RVALID comes from stage 2.
// TESTING
//  1 Reset: assert RESET mid-read -> all outputs at reset values; no RVALID after release;
//    first contention goes to port 0.
//  2 Single read: port0 REQ, WE=0, ADDR=5'h01 -> GNT0 same cycle; RVALID0 2 edges later
//    with Q0 = value preloaded at 0x01.
//  3 Write/readback: port1 writes 8'hA5 to 5'h1E, then reads 5'h1E back-to-back
//    -> RVALID1 with Q1=8'hA5; RAM_WE=1 for exactly one cycle.
//  4 Contention: both REQ held for 12 cycles with MAX_BURST=4
//    -> grants 0,0,0,0,1,1,1,1,0,0,0,0; RVALIDs ordered and tagged to the correct port.
//  5 Solo burst: port0 REQ held for 10 cycles, port1 idle -> 10 consecutive GNT0 with no gaps;
//    port1 raising REQ mid-burst is granted within <=MAX_BURST cycles.
//  6 Release: owner drops REQ while other idle -> IDLE next cycle, RAM_WE=0,
//    RAM_ADDRESS holds its last value.

Source files
------------

// File: rtl/mem_ram_arbiter_if.sv
// Requester-side bundle for the two-port RAM arbiter: command handshake plus read return.
interface mem_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] d0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] q0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] d1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] q1;

  // Requester view: drives commands, observes grant and read return.
  modport master (
    output req0, we0, addr0, d0,
    output req1, we1, addr1, d1,
    input  gnt0, rvalid0, q0,
    input  gnt1, rvalid1, q1
  );

  // Arbiter view.
  modport slave (
    input  req0, we0, addr0, d0,
    input  req1, we1, addr1, d1,
    output gnt0, rvalid0, q0,
    output gnt1, rvalid1, q1
  );
endinterface

// File: rtl/mem_ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters. Round-robin ownership with
// bounded bursts, registered RAM command, and tagged read-valid returned two edges after accept.
module mem_ram_arbiter #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_ram_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_d_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;     // 1: port 0 wins the next tie
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_c, gnt1_c;

  logic              accept_c;
  logic              cmd_we_c;
  logic [ADDR_W-1:0] cmd_addr_c;
  logic [DATA_W-1:0] cmd_d_c;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_d_q;
  logic              ram_we_q;
  logic              tag_v_q, tag_p_q;   // first stage of the read-return tag
  logic              rvalid0_q, rvalid1_q;

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and grant decode; the owner keeps the RAM until its burst budget is spent
  // while the other port waits.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 && bus.req1) begin
          cnt_d = CNT_ONE;
          if (last_q) begin
            gnt0_c  = 1'b1;
            state_d = S_OWN0;
            last_d  = 1'b0;
          end else begin
            gnt1_c  = 1'b1;
            state_d = S_OWN1;
            last_d  = 1'b1;
          end
        end else if (bus.req0) begin
          gnt0_c  = 1'b1;
          state_d = S_OWN0;
          cnt_d   = CNT_ONE;
        end else if (bus.req1) begin
          gnt1_c  = 1'b1;
          state_d = S_OWN1;
          cnt_d   = CNT_ONE;
        end
      end
      S_OWN0: begin
        if (bus.req0 && ((cnt_q < CNT_MAX) || !bus.req1)) begin
          gnt0_c = 1'b1;
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else if (bus.req1) begin
          gnt1_c  = 1'b1;
          state_d = S_OWN1;
          cnt_d   = CNT_ONE;
          last_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_OWN1: begin
        if (bus.req1 && ((cnt_q < CNT_MAX) || !bus.req0)) begin
          gnt1_c = 1'b1;
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else if (bus.req0) begin
          gnt0_c  = 1'b1;
          state_d = S_OWN0;
          cnt_d   = CNT_ONE;
          last_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Command mux: select the granted port's command.
  always_comb begin
    accept_c   = gnt0_c | gnt1_c;
    cmd_we_c   = gnt1_c ? bus.we1   : bus.we0;
    cmd_addr_c = gnt1_c ? bus.addr1 : bus.addr0;
    cmd_d_c    = gnt1_c ? bus.d1    : bus.d0;
  end

  // RAM command registers and the two-stage {valid,port} read tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_q <= '0;
      ram_d_q    <= '0;
      ram_we_q   <= 1'b0;
      tag_v_q    <= 1'b0;
      tag_p_q    <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        ram_addr_q <= cmd_addr_c;
        ram_d_q    <= cmd_d_c;
        ram_we_q   <= cmd_we_c;
      end else begin
        ram_we_q   <= 1'b0;
      end
      tag_v_q   <= accept_c & ~cmd_we_c;
      tag_p_q   <= gnt1_c;
      rvalid0_q <= tag_v_q & ~tag_p_q;
      rvalid1_q <= tag_v_q & tag_p_q;
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.q0        = ram_q_i;
  assign bus.q1        = ram_q_i;
  assign ram_address_o = ram_addr_q;
  assign ram_d_o       = ram_d_q;
  assign ram_we_o      = ram_we_q;

endmodule
